// File: rtl/rgmii_tx_sdr_serializer_if.sv
// MAC-side and RGMII-side signal bundle for rgmii_tx_sdr_serializer.
interface rgmii_tx_sdr_serializer_if #(
  parameter int FRAME_CNT_WIDTH = 16
);
  logic [1:0]                 speed_i;
  logic [7:0]                 gmii_txd_i;
  logic                       gmii_tx_en_i;
  logic                       gmii_tx_er_i;
  logic                       tx_ce_o;
  logic                       phase_o;
  logic [3:0]                 rgmii_txd_o;
  logic                       rgmii_tx_ctl_o;
  logic                       rgmii_tx_clk_o;
  logic [FRAME_CNT_WIDTH-1:0] frames_o;

  modport master (
    output speed_i, gmii_txd_i, gmii_tx_en_i, gmii_tx_er_i,
    input  tx_ce_o, phase_o, rgmii_txd_o, rgmii_tx_ctl_o, rgmii_tx_clk_o, frames_o
  );

  modport slave (
    input  speed_i, gmii_txd_i, gmii_tx_en_i, gmii_tx_er_i,
    output tx_ce_o, phase_o, rgmii_txd_o, rgmii_tx_ctl_o, rgmii_tx_clk_o, frames_o
  );
endinterface

// File: rtl/rgmii_tx_sdr_serializer.sv
// GMII-to-RGMII single-data-rate transmit serializer with frame counter.
// Optional macro RGMII_TX_CLK90_EN: re-time rgmii_tx_clk_o on the falling edge.
module rgmii_tx_sdr_serializer #(
  parameter int FRAME_CNT_WIDTH = 16
) (
  input logic                      gtx_clk250,
  input logic                      tx_rst,
  rgmii_tx_sdr_serializer_if.slave bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                     state, state_nxt;
  logic [6:0]                 div_cnt, div_nxt, period_nxt;
  logic [1:0]                 speed_r, speed_nxt;
  logic [7:0]                 hold_txd, txd_nxt;
  logic                       hold_en, hold_er, en_nxt, er_nxt;
  logic                       wrap, first_half;
  logic                       ce_nxt, ctl_nxt;
  logic [3:0]                 data_nxt;
  logic [FRAME_CNT_WIDTH-1:0] frames;
  logic                       tx_ce_q, ctl_q, clk_q;
  logic [3:0]                 txd_q;

  function automatic logic [6:0] period_of(input logic [1:0] s);
    case (s)
      2'b00:   return 7'd100;
      2'b01:   return 7'd10;
      default: return 7'd2;
    endcase
  endfunction

  // Output registers are loaded from the next-cycle state so that captured
  // data appears on the wire exactly one cycle after the capture cycle.
  always_comb begin
    wrap       = (div_cnt == period_of(speed_r) - 7'd1);
    div_nxt    = wrap ? '0 : div_cnt + 7'd1;
    speed_nxt  = wrap ? bus.speed_i : speed_r;
    txd_nxt    = wrap ? bus.gmii_txd_i : hold_txd;
    en_nxt     = wrap ? bus.gmii_tx_en_i : hold_en;
    er_nxt     = wrap ? bus.gmii_tx_er_i : hold_er;
    period_nxt = period_of(speed_nxt);
    first_half = (div_nxt < (period_nxt >> 1));
    ce_nxt     = (div_nxt >= period_nxt - 7'd2);
    ctl_nxt    = first_half ? en_nxt : (en_nxt ^ er_nxt);
    data_nxt   = '0;
    if (en_nxt || er_nxt) begin
      if (period_nxt == 7'd2 && div_nxt[0]) data_nxt = txd_nxt[7:4];
      else                                  data_nxt = txd_nxt[3:0];
    end
  end

  always_comb begin
    state_nxt = state;
    if (wrap) begin
      case (state)
        IDLE:    if (bus.gmii_tx_en_i)  state_nxt = ACTIVE;
        ACTIVE:  if (!bus.gmii_tx_en_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) begin
      div_cnt  <= '0;
      speed_r  <= 2'b10;
      hold_txd <= '0;
      hold_en  <= 1'b0;
      hold_er  <= 1'b0;
      frames   <= '0;
      tx_ce_q  <= 1'b0;
      txd_q    <= '0;
      ctl_q    <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      div_cnt  <= div_nxt;
      speed_r  <= speed_nxt;
      hold_txd <= txd_nxt;
      hold_en  <= en_nxt;
      hold_er  <= er_nxt;
      if (state == ACTIVE && state_nxt == IDLE) frames <= frames + 1'b1;
      tx_ce_q  <= ce_nxt;
      txd_q    <= data_nxt;
      ctl_q    <= ctl_nxt;
      clk_q    <= first_half;
    end
  end

`ifdef RGMII_TX_CLK90_EN
  logic clk90_q;

  always_ff @(negedge gtx_clk250 or posedge tx_rst) begin
    if (tx_rst) clk90_q <= 1'b0;
    else        clk90_q <= clk_q;
  end

  assign bus.rgmii_tx_clk_o = clk90_q;
`else
  assign bus.rgmii_tx_clk_o = clk_q;
`endif

  assign bus.tx_ce_o        = tx_ce_q;
  assign bus.phase_o        = div_cnt[0];
  assign bus.rgmii_txd_o    = txd_q;
  assign bus.rgmii_tx_ctl_o = ctl_q;
  assign bus.frames_o       = frames;
endmodule

// File: tb/tb_rgmii_tx_sdr_serializer.sv
// Directed self-checking bench for rgmii_tx_sdr_serializer (plus a 2-bit counter copy for wrap).
`timescale 1ns/1ps
module tb_rgmii_tx_sdr_serializer;
  logic gtx_clk250 = 1'b0;
  logic tx_rst;
  logic clk_early;
  int   n_checks, n_errors;
  int   ce_hi, clk_hi;

`ifdef RGMII_TX_CLK90_EN
  localparam logic CLK_EARLY_EXP = 1'b0;
`else
  localparam logic CLK_EARLY_EXP = 1'b1;
`endif

  always #2 gtx_clk250 = ~gtx_clk250;

  rgmii_tx_sdr_serializer_if #(.FRAME_CNT_WIDTH(16)) bus ();
  rgmii_tx_sdr_serializer_if #(.FRAME_CNT_WIDTH(2))  bus_w ();

  assign bus_w.speed_i      = bus.speed_i;
  assign bus_w.gmii_txd_i   = bus.gmii_txd_i;
  assign bus_w.gmii_tx_en_i = bus.gmii_tx_en_i;
  assign bus_w.gmii_tx_er_i = bus.gmii_tx_er_i;

  rgmii_tx_sdr_serializer #(.FRAME_CNT_WIDTH(16)) dut (
    .gtx_clk250(gtx_clk250), .tx_rst(tx_rst), .bus(bus)
  );
  rgmii_tx_sdr_serializer #(.FRAME_CNT_WIDTH(2)) dut_w (
    .gtx_clk250(gtx_clk250), .tx_rst(tx_rst), .bus(bus_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gtx_clk250);
    #3;
  endtask

  task automatic out_chk(input string tag, input logic [3:0] txd, input logic ctl, input logic clk);
    chk({tag, "_txd"}, bus.rgmii_txd_o, txd);
    chk({tag, "_ctl"}, bus.rgmii_tx_ctl_o, ctl);
    chk({tag, "_clk"}, bus.rgmii_tx_clk_o, clk);
  endtask

  // Advance to the next capture cycle (div_cnt == N-1), then present new inputs.
  task automatic drive(input logic [1:0] spd, input logic [7:0] d, input logic en, input logic er);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.tx_ce_o && bus.phase_o) && n < 300);
    chk("capture_reached", bus.tx_ce_o && bus.phase_o, 1);
    bus.speed_i      = spd;
    bus.gmii_txd_i   = d;
    bus.gmii_tx_en_i = en;
    bus.gmii_tx_er_i = er;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    tx_rst = 1'b1;
    bus.speed_i = 2'b10;
    bus.gmii_txd_i = 8'h00;
    bus.gmii_tx_en_i = 1'b0;
    bus.gmii_tx_er_i = 1'b0;
    repeat (3) tick();

    chk("rst_tx_ce", bus.tx_ce_o, 0);
    chk("rst_phase", bus.phase_o, 0);
    out_chk("rst", 4'h0, 1'b0, 1'b0);
    chk("rst_frames", bus.frames_o, 0);

    // First capture after release must be at div_cnt = 1
    tx_rst = 1'b0;
    bus.gmii_txd_i = 8'h96;
    bus.gmii_tx_en_i = 1'b1;
    tick();
    chk("rel_phase", bus.phase_o, 1);
    chk("rel_tx_ce", bus.tx_ce_o, 1);
    out_chk("rel_div1", 4'h0, 1'b0, 1'b0);
    @(posedge gtx_clk250);
    #1 clk_early = bus.rgmii_tx_clk_o;
    #2;
    chk("clk_edge_align", clk_early, CLK_EARLY_EXP);
    out_chk("cap96_lo", 4'h6, 1'b1, 1'b1);
    tick();
    out_chk("cap96_hi", 4'h9, 1'b1, 1'b0);

    drive(2'b10, 8'h5A, 1'b1, 1'b0);
    tick();
    out_chk("g5a_lo", 4'hA, 1'b1, 1'b1);
    chk("g5a_phase0", bus.phase_o, 0);
    chk("g5a_ce0", bus.tx_ce_o, 1);
    tick();
    out_chk("g5a_hi", 4'h5, 1'b1, 1'b0);
    chk("g5a_phase1", bus.phase_o, 1);

    drive(2'b10, 8'h3C, 1'b1, 1'b1);
    tick();
    out_chk("er11_lo", 4'hC, 1'b1, 1'b1);
    tick();
    out_chk("er11_hi", 4'h3, 1'b0, 1'b0);

    drive(2'b10, 8'h0F, 1'b0, 1'b1);
    tick();
    out_chk("er01_lo", 4'hF, 1'b0, 1'b1);
    chk("frames_1", bus.frames_o, 1);
    tick();
    out_chk("er01_hi", 4'h0, 1'b1, 1'b0);

    drive(2'b10, 8'hFF, 1'b0, 1'b0);
    tick();
    out_chk("idle_lo", 4'h0, 1'b0, 1'b1);
    tick();
    out_chk("idle_hi", 4'h0, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 8'h11, 1'b1, 1'b0);
      drive(2'b10, 8'h11, 1'b0, 1'b0);
    end
    tick();
    chk("frames_3", bus.frames_o, 3);
    chk("frames_w_3", bus_w.frames_o, 3);
    drive(2'b10, 8'h22, 1'b1, 1'b0);
    drive(2'b10, 8'h22, 1'b0, 1'b0);
    tick();
    chk("frames_4", bus.frames_o, 4);
    chk("frames_w_wrap", bus_w.frames_o, 0);

    // 100 Mb/s: N = 10
    drive(2'b01, 8'hA3, 1'b1, 1'b0);
    ce_hi = 0;
    clk_hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("m100_phase", bus.phase_o, i % 2);
      chk("m100_ce", bus.tx_ce_o, (i >= 8) ? 1 : 0);
      out_chk("m100", 4'h3, 1'b1, (i < 5) ? 1'b1 : 1'b0);
      ce_hi += int'(bus.tx_ce_o);
      clk_hi += int'(bus.rgmii_tx_clk_o);
    end
    chk("m100_ce_count", ce_hi, 2);
    chk("m100_clk_count", clk_hi, 5);

    // Back to 1000, then request 10 during div_cnt = 0
    drive(2'b10, 8'h87, 1'b1, 1'b0);
    tick();
    chk("sc_ce0", bus.tx_ce_o, 1);
    chk("sc_phase0", bus.phase_o, 0);
    out_chk("sc_lo", 4'h7, 1'b1, 1'b1);
    bus.speed_i = 2'b00;
    tick();
    chk("sc_ce1", bus.tx_ce_o, 1);
    chk("sc_phase1", bus.phase_o, 1);
    out_chk("sc_hi", 4'h8, 1'b1, 1'b0);
    ce_hi = 0;
    clk_hi = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("m10_phase", bus.phase_o, i % 2);
      chk("m10_ce", bus.tx_ce_o, (i >= 98) ? 1 : 0);
      out_chk("m10", 4'h7, 1'b1, (i < 50) ? 1'b1 : 1'b0);
      ce_hi += int'(bus.tx_ce_o);
      clk_hi += int'(bus.rgmii_tx_clk_o);
    end
    chk("m10_ce_count", ce_hi, 2);
    chk("m10_clk_count", clk_hi, 50);

    // Abort the active frame with reset
    tick();
    tx_rst = 1'b1;
    #0.5;
    chk("abort_tx_ce", bus.tx_ce_o, 0);
    chk("abort_phase", bus.phase_o, 0);
    out_chk("abort", 4'h0, 1'b0, 1'b0);
    chk("abort_frames", bus.frames_o, 0);
    bus.speed_i = 2'b10;
    bus.gmii_tx_en_i = 1'b0;
    tick();
    tx_rst = 1'b0;
    repeat (4) tick();
    chk("post_abort_frames", bus.frames_o, 0);
    chk("post_abort_frames_w", bus_w.frames_o, 0);
    out_chk("post_abort", 4'h0, 1'b0, bus.phase_o ? 1'b0 : 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rgmii_tx_sdr_serializer.md
RGMII_TX_SDR_SERIALIZER -- requirements
Module: rgmii_tx_sdr_serializer

Interface
REQ-001 Parameter FRAME_CNT_WIDTH, default 16: width of the transmitted-frame counter.
REQ-002 Port gtx_clk250  input  1  250 MHz transmit clock; all logic on its rising edge except per REQ-030.
REQ-003 Port tx_rst  input  1  reset: asynchronous, active-high, synchronous to gtx_clk250 on release.
REQ-004 Port speed_i  input  2  link speed: 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 treated as 1000.
REQ-005 Port gmii_txd_i  input  8  MAC byte (1000) or nibble in bits [3:0] (10/100).
REQ-006 Port gmii_tx_en_i  input  1  MAC transmit enable.
REQ-007 Port gmii_tx_er_i  input  1  MAC transmit error.
REQ-008 Port tx_ce_o  output  1  clock enable to MAC; one gtx_clk period (2 cycles) per nibble period.
REQ-009 Port phase_o  output  1  equals div_cnt[0]; 1 marks the sample cycle.
REQ-010 Port rgmii_txd_o  output  4  registered RGMII data.
REQ-011 Port rgmii_tx_ctl_o  output  1  registered RGMII control.
REQ-012 Port rgmii_tx_clk_o  output  1  registered RGMII transmit clock.
REQ-013 Port frames_o  output  FRAME_CNT_WIDTH  count of completed frames.

Function
REQ-014 Period N in gtx_clk250 cycles: 2 (1000), 10 (100), 100 (10).
REQ-015 div_cnt (7 bits) increments every cycle, wraps N-1 -> 0.
REQ-016 speed_r loads from speed_i only in the cycle div_cnt == N-1; new N applies from the following div_cnt = 0.
REQ-017 On the cycle div_cnt == N-1, txd/en/er are captured into hold registers.
REQ-018 tx_ce_o = 1 when div_cnt is N-2 or N-1; constant 1 at 1000.
REQ-019 Outputs are registered; they reflect the captured values one cycle after capture.
REQ-020 First half (div_cnt 0..N/2-1): rgmii_tx_clk_o = 1, rgmii_tx_ctl_o = en.
REQ-021 Second half (div_cnt N/2..N-1): rgmii_tx_clk_o = 0, rgmii_tx_ctl_o = en XOR er.
REQ-022 1000 data: low nibble while div_cnt = 0, high nibble while div_cnt = 1.
REQ-023 10/100 data: captured bits [3:0] held for the whole period.
REQ-024 When captured en = 0 and er = 0, rgmii_txd_o = 0.
REQ-025 Frame FSM states: IDLE -> ACTIVE on captured en = 1; ACTIVE -> IDLE on captured en = 0.
REQ-026 frames_o increments on each ACTIVE -> IDLE transition and wraps modulo 2^FRAME_CNT_WIDTH.
REQ-027 A speed change mid-frame is not blocked; it applies at the next wrap per REQ-016.

Reset
REQ-028 While tx_rst = 1: div_cnt = 0, speed_r = 2'b10, FSM = IDLE, hold registers = 0, tx_ce_o = 0, phase_o = 0, rgmii_txd_o = 0, rgmii_tx_ctl_o = 0, rgmii_tx_clk_o = 0, frames_o = 0.
REQ-029 Reset asserted mid-frame forces all values in REQ-028 immediately, with no frame count; after release, the first capture occurs at div_cnt = 1 (1000 mode).

Configuration
REQ-030 Macro RGMII_TX_CLK90_EN defined: rgmii_tx_clk_o is re-registered on the falling edge of gtx_clk250, lagging data by 2 ns (90 degrees at 1000).
REQ-031 Macro RGMII_TX_CLK90_EN undefined: rgmii_tx_clk_o comes from the rising-edge register and is edge-aligned with rgmii_txd_o.

Verification
REQ-032 Scenario 1000: byte 0x5A, en = 1, er = 0 captured -> next cycle txd = 0xA, ctl = 1, clk = 1; following cycle txd = 0x5, ctl = 1, clk = 0.
REQ-033 Scenario error: en = 1, er = 1 at 1000 -> ctl 1 then 0; en = 0, er = 1 -> ctl 0 then 1.
REQ-034 Scenario 100: speed 01, nibble 0x3 -> tx_ce_o high 2 of every 10 cycles; clk high 5 / low 5; txd = 0x3 for 10 cycles.
REQ-035 Scenario speed change: speed 10 -> 00 applied at div_cnt = 0 -> N stays 2 until the wrap, then period = 100, clk high 50 / low 50.
REQ-036 Scenario reset and counter: 3 frames -> frames_o = 3; preload to 0xFFFF plus 1 frame -> 0; tx_rst mid-frame -> all outputs 0 that cycle, frames_o unchanged by the aborted frame.
REQ-037 Scenario macro: with RGMII_TX_CLK90_EN, the clk edge lags the txd transition by half a gtx_clk250 cycle; without it, the two are coincident.
